// File: rtl/fa_bist_pkg.sv
// Shared types and golden full-adder model for the fa_bist controller.
package fa_bist_pkg;

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   localparam int unsigned NUM_VECTORS = 8;

   // Returns {carry, sum} for operands {a, b, cin} = idx.
   function automatic logic [1:0] fa_golden(input logic [2:0] idx);
      logic sum;
      logic carry;
      sum   = ^idx;
      carry = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
      return {carry, sum};
   endfunction

endpackage

// File: rtl/fa_bist.sv
// BIST controller: drives all eight vectors into an external full adder, checks each
// response against the golden model and reports pass, mismatch count and first failure.
module fa_bist
   import fa_bist_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       fa_sum,
   input  logic       fa_carry,
   output logic       fa_a,
   output logic       fa_b,
   output logic       fa_cin,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] first_fail_vec
);

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LastIdx    = 3'(NUM_VECTORS - 1);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] ops_q, ops_d;
   logic [3:0] settle_q, settle_d;
   logic [3:0] err_q, err_d;
   logic       fail_valid_q, fail_valid_d;
   logic [2:0] first_fail_q, first_fail_d;
   logic       pass_q, pass_d;
   logic       mismatch;

   assign mismatch = ({fa_carry, fa_sum} != fa_golden(idx_q));

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      ops_d        = ops_q;
      settle_d     = settle_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StDrive;
               idx_d        = 3'd0;
               ops_d        = 3'd0;
               settle_d     = 4'd0;
               err_d        = 4'd0;
               fail_valid_d = 1'b0;
               first_fail_d = 3'd0;
               pass_d       = 1'b0;
            end
         end
         StDrive: begin
            settle_d = settle_q + 4'd1;
            if (settle_q == SettleLast) begin
               state_d = StSample;
            end
         end
         StSample: begin
            if (mismatch) begin
               err_d = err_q + 4'd1;
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  first_fail_d = idx_q;
               end
            end
            if (idx_q == LastIdx) begin
               state_d = StDone;
               ops_d   = 3'd0;
               pass_d  = (err_d == 4'd0);
            end else begin
               state_d  = StDrive;
               idx_d    = idx_q + 3'd1;
               ops_d    = idx_q + 3'd1;
               settle_d = 4'd0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         idx_q        <= 3'd0;
         ops_q        <= 3'd0;
         settle_q     <= 4'd0;
         err_q        <= 4'd0;
         fail_valid_q <= 1'b0;
         first_fail_q <= 3'd0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         ops_q        <= ops_d;
         settle_q     <= settle_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
      end
   end

   assign {fa_a, fa_b, fa_cin} = ops_q;
   assign busy                 = (state_q == StDrive) || (state_q == StSample);
   assign done                 = (state_q == StDone);
   assign pass                 = pass_q;
   assign err_count            = err_q;
   assign fail_valid           = fail_valid_q;
   assign first_fail_vec       = first_fail_q;

endmodule

// File: tb/tb_fa_bist.sv
// Scoreboard bench for fa_bist: two instances (settle 1 and 3) with behavioural faulty adders.
module tb_fa_bist;

   localparam int S1 = 1;
   localparam int S3 = 3;

   typedef struct {
      logic       pass;
      int         err;
      logic       fv;
      logic [2:0] ffv;
      int         start_edge;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst    = 1'b1;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   passed = 0;

   int          mode1 = 0, mode3 = 0, dly1 = 0, dly3 = 0;
   logic [15:0] mask1 = '0, mask3 = '0;

   logic       a1, b1, c1, sum1, car1, busy1, done1, pass1, fv1;
   logic       a3, b3, c3, sum3, car3, busy3, done3, pass3, fv3;
   logic [3:0] err1, err3;
   logic [2:0] ffv1, ffv3;
   logic [2:0] h1_0, h1_1, h3_0, h3_1, src1, src3;

   exp_t q1[$];
   exp_t q3[$];

   fa_bist #(.SETTLE_CYCLES(S1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .fa_sum(sum1), .fa_carry(car1),
      .fa_a(a1), .fa_b(b1), .fa_cin(c1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_valid(fv1), .first_fail_vec(ffv1)
   );

   fa_bist #(.SETTLE_CYCLES(S3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .fa_sum(sum3), .fa_carry(car3),
      .fa_a(a3), .fa_b(b3), .fa_cin(c3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_valid(fv3), .first_fail_vec(ffv3)
   );

   // Adder under test: arithmetic sum with an optional fault; returns {carry, sum}.
   function automatic logic [1:0] fa_model(input int mode, input logic [15:0] mask,
                                           input logic [2:0] v);
      logic [1:0] r;
      r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      case (mode)
         1: r[0] = 1'b0;
         2: r[1] = ~r[1];
         3: r = r ^ mask[int'(v) * 2 +: 2];
         default: ;
      endcase
      return r;
   endfunction

   // Vector i is applied for s+1 cycles starting at cycle i*(s+1) after the start edge and is
   // sampled in its last cycle; with a d-cycle adder delay the sample sees the operand at t-d.
   function automatic exp_t ref_run(input int s, input int d, input int mode,
                                    input logic [15:0] mask, input int start_edge);
      exp_t e;
      int   t;
      int   ts;
      logic [2:0] src;
      e.err = 0; e.fv = 1'b0; e.ffv = 3'd0;
      for (int i = 0; i < 8; i++) begin
         t   = i * (s + 1) + s;
         ts  = t - d;
         src = (ts < 0) ? 3'd0 : 3'(ts / (s + 1));
         if (fa_model(mode, mask, src) != fa_model(0, 16'd0, 3'(i))) begin
            e.err++;
            if (!e.fv) begin
               e.fv  = 1'b1;
               e.ffv = 3'(i);
            end
         end
      end
      e.pass       = (e.err == 0);
      e.start_edge = start_edge;
      e.lat        = 8 * (s + 1);
      return e;
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      h1_0 <= {a1, b1, c1};
      h1_1 <= h1_0;
      h3_0 <= {a3, b3, c3};
      h3_1 <= h3_0;
   end

   always_comb begin
      src1 = {a1, b1, c1};
      if (dly1 == 1) src1 = h1_0;
      else if (dly1 == 2) src1 = h1_1;
      {car1, sum1} = fa_model(mode1, mask1, src1);
      src3 = {a3, b3, c3};
      if (dly3 == 1) src3 = h3_0;
      else if (dly3 == 2) src3 = h3_1;
      {car3, sum3} = fa_model(mode3, mask3, src3);
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check_result(input string tag, input exp_t e, input logic p,
                               input logic [3:0] ec, input logic fv, input logic [2:0] ffv);
      check({tag, " latency"}, cyc - e.start_edge, e.lat);
      check({tag, " pass"}, int'(p), int'(e.pass));
      check({tag, " err_count"}, int'(ec), e.err);
      check({tag, " fail_valid"}, int'(fv), int'(e.fv));
      if (e.fv) check({tag, " first_fail_vec"}, int'(ffv), int'(e.ffv));
   endtask

   // Monitors: pop and compare on each rising edge of done.
   logic pd1 = 1'b0, pd3 = 1'b0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (done1 && !pd1) begin
         if (q1.size() == 0) check("dut1 unexpected done", 0, 1);
         else begin
            e = q1.pop_front();
            check_result("dut1", e, pass1, err1, fv1, ffv1);
         end
      end
      if (done3 && !pd3) begin
         if (q3.size() == 0) check("dut3 unexpected done", 0, 1);
         else begin
            e = q3.pop_front();
            check_result("dut3", e, pass3, err3, fv3, ffv3);
         end
      end
      pd1 = done1;
      pd3 = done3;
   end

   task automatic wait_done(input int which);
      int n = 0;
      while (!((which == 1) ? done1 : done3)) begin
         @(negedge clk);
         n++;
         if (n > 400) begin
            check("done timeout", 0, 1);
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic run(input int which, input int mode, input logic [15:0] mask, input int d);
      if (which == 1) begin
         mode1 = mode; mask1 = mask; dly1 = d;
         q1.push_back(ref_run(S1, d, mode, mask, cyc + 1));
         start1 = 1'b1;
      end else begin
         mode3 = mode; mask3 = mask; dly3 = d;
         q3.push_back(ref_run(S3, d, mode, mask, cyc + 1));
         start3 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      wait_done(which);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " operands"}, int'({a1, b1, c1}), 0);
      check({tag, " busy/done/pass"}, int'({busy1, done1, pass1}), 0);
      check({tag, " err_count"}, int'(err1), 0);
      check({tag, " fail_valid/first"}, int'({fv1, ffv1}), 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      check("reset dut3", int'({a3, b3, c3, busy3, done3, pass3, err3, fv3, ffv3}), 0);
      rst = 1'b0;
      @(negedge clk);

      run(1, 0, 16'd0, 0);            // good adder
      run(1, 1, 16'd0, 0);            // sum stuck at 0
      run(1, 2, 16'd0, 0);            // carry inverted
      run(1, 0, 16'd0, 0);            // restart from DONE, fixed adder

      // start held for the whole run, then still high in DONE
      mode1 = 0; dly1 = 0;
      q1.push_back(ref_run(S1, 0, 0, 16'd0, cyc + 1));
      start1 = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done1 && n < 100);
      check("held start reaches done", int'(done1), 1);
      q1.push_back(ref_run(S1, 0, 0, 16'd0, cyc + 1));
      @(negedge clk);
      check("restart drops done", int'({done1, busy1}), 1);
      start1 = 1'b0;
      wait_done(1);

      // reset during DRIVE of vector 3
      mode1 = 0;
      q1.push_back(ref_run(S1, 0, 0, 16'd0, cyc + 1));
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!(busy1 && {a1, b1, c1} == 3'd3) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reached vector 3", int'({a1, b1, c1}), 3);
      rst = 1'b1;
      void'(q1.pop_back());
      @(negedge clk);
      check_quiet("abort");
      rst = 1'b0;
      @(negedge clk);
      run(1, 0, 16'd0, 0);

      // settle/delay interaction
      run(3, 0, 16'd0, 2);
      run(1, 0, 16'd0, 2);

      for (int i = 0; i < 6; i++) begin
         run(1, int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 2)));
         run(3, int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      check("dut1 scoreboard drained", q1.size(), 0);
      check("dut3 scoreboard drained", q3.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
